// File: rtl/vram_pkg.sv
// Shared video RAM geometry and encodings, used by the arbiter, its fill engine
// and the video timing generator.
package vram_pkg;

    localparam int VRAM_ADDR_W    = 15;     // {row[8:0], byte column[5:0]}
    localparam int VRAM_DATA_W    = 8;      // 8 pixels per byte, MSB leftmost
    localparam int VRAM_FILL_LAST = 16383;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    typedef enum logic {
        SRC_DISP = 1'b0,
        SRC_HOST = 1'b1
    } rd_src_e;

endpackage

// File: rtl/vram_fill.sv
// Screen fill engine: writes a latched pattern to addresses 0..FILL_LAST,
// advancing only on cycles where the arbiter lets its write through.
module vram_fill
    import vram_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int FILL_LAST = VRAM_FILL_LAST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_pattern,
    input  logic              wr_grant,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FILL_LAST);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    pat_d   = fill_pattern;
                end
            end
            FILL: begin
                // fill_start is deliberately ignored while a fill is running
                if (wr_grant) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_busy  = (state_q == FILL);
    assign fill_done  = done_q;
    assign fill_addr  = cnt_q;
    assign fill_wdata = pat_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display > host > fill, fixed per cycle.
// Read data is steered back to its requester by a one-cycle source tag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int FILL_LAST = VRAM_FILL_LAST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              host_grant;
    logic              fill_grant;
    logic              rd_issue;
    rd_src_e           rd_src_q, rd_src_d;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] disp_hold_q;
    logic [DATA_W-1:0] host_hold_q;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_wdata;

    vram_fill #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FILL_LAST (FILL_LAST)
    ) u_fill (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_start   (fill_start),
        .fill_pattern (fill_pattern),
        .wr_grant     (fill_grant),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .fill_addr    (fill_addr),
        .fill_wdata   (fill_wdata)
    );

    // The display is never stalled, so the host simply waits out display cycles.
    assign host_ready = !disp_req;
    assign host_grant = host_req && !disp_req;
    assign fill_grant = fill_busy && !disp_req && !host_req;

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = host_wdata;
        rd_issue  = 1'b0;
        rd_src_d  = rd_src_q;
        if (disp_req) begin
            mem_addr = disp_addr;
            rd_issue = 1'b1;
            rd_src_d = SRC_DISP;
        end else if (host_grant) begin
            mem_addr = host_addr;
            mem_we   = host_we;
            if (!host_we) begin
                rd_issue = 1'b1;
                rd_src_d = SRC_HOST;
            end
        end else if (fill_grant) begin
            mem_addr  = fill_addr;
            mem_we    = 1'b1;
            mem_wdata = fill_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_src_q    <= SRC_DISP;
            disp_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            addr_q      <= mem_addr;
            rd_pend_q   <= rd_issue;
            rd_src_q    <= rd_src_d;
            disp_hold_q <= disp_data;
            host_hold_q <= host_rdata;
        end
    end

    // RAM data is only live for one cycle; outside the strobe the last value is held.
    assign disp_valid  = rd_pend_q && (rd_src_q == SRC_DISP);
    assign host_rvalid = rd_pend_q && (rd_src_q == SRC_HOST);
    assign disp_data   = disp_valid  ? mem_rdata : disp_hold_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: arbitration table, directed corner sequences and
// random traffic, all checked against a cycle-level model of the access rules.
module tb_vram_arbiter;

    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int LAST = 63;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          fill_start;
    logic [DW-1:0] fill_pattern;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FILL_LAST(LAST)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .fill_start(fill_start), .fill_pattern(fill_pattern), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port RAM, unwritten locations read as zero.
    logic [DW-1:0] ram [int];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory image plus fill progress as plain integers.
    logic [DW-1:0] exp_mem [int];
    bit            m_busy, m_dv, m_hv, m_done;
    int            m_cnt;
    logic [DW-1:0] m_pat, m_dd, m_hd;
    logic [AW-1:0] m_last;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dv = 0; m_hv = 0; m_done = 0;
        m_cnt = 0; m_pat = '0; m_dd = '0; m_hd = '0; m_last = '0;
    endtask

    task automatic model_cycle();
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wd;
        bit            n_dv, n_hv, n_done, was_busy;
        logic [DW-1:0] n_dd, n_hd;
        n_dv = 0; n_hv = 0; n_done = 0; n_dd = '0; n_hd = '0;
        was_busy = m_busy;
        chk("disp_valid", 32'(disp_valid), 32'(m_dv));
        if (m_dv) chk("disp_data", 32'(disp_data), 32'(m_dd));
        chk("host_rvalid", 32'(host_rvalid), 32'(m_hv));
        if (m_hv) chk("host_rdata", 32'(host_rdata), 32'(m_hd));
        chk("fill_busy", 32'(fill_busy), 32'(m_busy));
        chk("fill_done", 32'(fill_done), 32'(m_done));
        chk("host_ready", 32'(host_ready), 32'(!disp_req));
        e_addr = m_last; e_we = 0; e_wd = '0;
        if (disp_req) begin
            e_addr = disp_addr; n_dv = 1; n_dd = exp_rd(disp_addr);
        end else if (host_req) begin
            e_addr = host_addr;
            if (host_we) begin e_we = 1; e_wd = host_wdata; end
            else begin n_hv = 1; n_hd = exp_rd(host_addr); end
        end else if (m_busy) begin
            e_addr = AW'(m_cnt); e_we = 1; e_wd = m_pat;
        end
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            exp_mem[int'(e_addr)] = e_wd;
        end
        if (was_busy && !disp_req && !host_req) begin
            if (m_cnt == LAST) begin m_busy = 0; n_done = 1; end
            else m_cnt++;
        end
        if (!was_busy && fill_start) begin
            m_busy = 1; m_cnt = 0; m_pat = fill_pattern;
        end
        m_last = e_addr; m_dv = n_dv; m_dd = n_dd; m_hv = n_hv; m_hd = n_hd; m_done = n_done;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        acc = 0;
        host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = !disp_req;
            cycle();
        end
        chk("host_write_accepted", 32'(acc), 32'd1);
        host_req = 0; host_we = 0;
        $display("host write %h <= %h", a, d);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 127));
    endfunction

    typedef struct {
        logic          dr;
        logic          hr;
        logic          hwe;
        logic [AW-1:0] da;
        logic [AW-1:0] ha;
        logic [DW-1:0] hwd;
        logic          exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit seen, acc;
        int gap;

        vecs[0] = '{dr:0, hr:1, hwe:1, da:'h0000, ha:'h0100, hwd:'h11, exp_ready:1, exp_we:1, exp_addr:'h0100};
        vecs[1] = '{dr:0, hr:0, hwe:0, da:'h0000, ha:'h0000, hwd:'h00, exp_ready:1, exp_we:0, exp_addr:'h0100};
        vecs[2] = '{dr:1, hr:1, hwe:1, da:'h0200, ha:'h0300, hwd:'h33, exp_ready:0, exp_we:0, exp_addr:'h0200};
        vecs[3] = '{dr:0, hr:1, hwe:1, da:'h0000, ha:'h0300, hwd:'h33, exp_ready:1, exp_we:1, exp_addr:'h0300};
        vecs[4] = '{dr:0, hr:1, hwe:0, da:'h0000, ha:'h0100, hwd:'h00, exp_ready:1, exp_we:0, exp_addr:'h0100};
        vecs[5] = '{dr:1, hr:0, hwe:0, da:'h0300, ha:'h0000, hwd:'h00, exp_ready:0, exp_we:0, exp_addr:'h0300};
        vecs[6] = '{dr:0, hr:0, hwe:0, da:'h0000, ha:'h0000, hwd:'h00, exp_ready:1, exp_we:0, exp_addr:'h0300};
        vecs[7] = '{dr:0, hr:1, hwe:0, da:'h0000, ha:'h7FFF, hwd:'h00, exp_ready:1, exp_we:0, exp_addr:'h7FFF};

        rst_n = 0; disp_req = 0; disp_addr = '0; host_req = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; fill_start = 0; fill_pattern = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst_n = 1;
        cycle();

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            disp_req = vecs[i].dr; disp_addr = vecs[i].da;
            host_req = vecs[i].hr; host_we = vecs[i].hwe;
            host_addr = vecs[i].ha; host_wdata = vecs[i].hwd;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(host_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            $display("vec %0d: dr=%b hr=%b we=%b -> mem_addr=%h mem_we=%b ready=%b",
                     i, vecs[i].dr, vecs[i].hr, vecs[i].hwe, mem_addr, mem_we, host_ready);
            cycle();
            disp_req = 0; host_req = 0; host_we = 0;
            if (vecs[i].dr) repeat (7) cycle();
        end
        repeat (8) cycle();

        // Display reads of a host-written byte, one every 8 cycles
        host_write(AW'('h2001), 8'hAA);
        repeat (8) cycle();
        for (int k = 0; k < 4; k++) begin
            disp_req = 1; disp_addr = AW'('h2001);
            cycle();
            disp_req = 0;
            chk("r037_valid", 32'(disp_valid), 32'd1);
            chk("r037_data", 32'(disp_data), 32'hAA);
            $display("display read 2001 #%0d -> %h valid=%b", k, disp_data, disp_valid);
            repeat (7) cycle();
        end

        // Host read colliding with a display fetch
        host_write(AW'('h1041), 8'h5C);
        repeat (8) cycle();
        disp_req = 1; disp_addr = AW'('h0005);
        host_req = 1; host_we = 0; host_addr = AW'('h1041);
        #1;
        chk("r038_ready_blocked", 32'(host_ready), 32'd0);
        cycle();
        disp_req = 0;
        #1;
        chk("r038_ready_next", 32'(host_ready), 32'd1);
        cycle();
        host_req = 0;
        chk("r038_rvalid", 32'(host_rvalid), 32'd1);
        chk("r038_rdata", 32'(host_rdata), 32'h5C);
        chk("r038_no_disp", 32'(disp_valid), 32'd0);
        $display("host read 1041 -> %h rvalid=%b", host_rdata, host_rvalid);
        repeat (8) cycle();

        // Uncontended fill: 64 back-to-back writes
        fill_pattern = 8'h00; fill_start = 1;
        cycle();
        fill_start = 0;
        for (int i = 0; i <= LAST; i++) begin
            chk("r039_we", 32'(mem_we), 32'd1);
            chk("r039_addr", 32'(mem_addr), 32'(i));
            cycle();
        end
        chk("r039_done", 32'(fill_done), 32'd1);
        chk("r039_busy_low", 32'(fill_busy), 32'd0);
        cycle();
        chk("r039_done_pulse", 32'(fill_done), 32'd0);
        $display("fill 0..%0d complete", LAST);

        // Fill starved by display plus continuous host reads
        fill_pattern = 8'h3C; fill_start = 1;
        cycle();
        fill_start = 0;
        host_req = 1; host_we = 0; host_addr = AW'($urandom_range(0, 63));
        for (int i = 0; i < 120; i++) begin
            disp_req = (i % 8 == 0);
            if (disp_req) disp_addr = AW'($urandom_range(0, 127));
            acc = !disp_req;
            cycle();
            if (acc) host_addr = AW'($urandom_range(0, 63));
        end
        disp_req = 0; host_req = 0;
        chk("r040_busy_held", 32'(fill_busy), 32'd1);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            disp_req = (i % 8 == 0);
            if (disp_req) disp_addr = AW'($urandom_range(0, 127));
            cycle();
            disp_req = 0;
            if (fill_done) seen = 1;
        end
        chk("r040_done_seen", 32'(seen), 32'd1);
        $display("contended fill finished seen=%0d", seen);
        repeat (8) cycle();

        // Reset in the middle of a fill
        fill_pattern = 8'h77; fill_start = 1;
        cycle();
        fill_start = 0;
        for (int i = 0; i < 200 && m_cnt != 20; i++) cycle();
        chk("r041_at_20", 32'(mem_addr), 32'd20);
        #2 rst_n = 0;
        #1;
        chk("r041_busy_now", 32'(fill_busy), 32'd0);
        chk("r041_no_done", 32'(fill_done), 32'd0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1;
        repeat (10) cycle();
        chk("r041_still_idle", 32'(fill_busy), 32'd0);
        fill_start = 1;
        cycle();
        fill_start = 0;
        chk("r041_restart_addr", 32'(mem_addr), 32'd0);
        chk("r041_restart_we", 32'(mem_we), 32'd1);
        $display("fill aborted at 20 and restarted at %h", mem_addr);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            if (fill_done) seen = 1;
        end
        chk("r041_restart_done", 32'(seen), 32'd1);

        // Random traffic against the model
        gap = 8;
        for (int i = 0; i < 3000; i++) begin
            gap++;
            disp_req = (gap >= 8) && ($urandom_range(0, 3) == 0);
            if (disp_req) begin gap = 0; disp_addr = rnd_addr(); end
            fill_start = ($urandom_range(0, 99) == 0);
            fill_pattern = DW'($urandom);
            acc = host_req && !disp_req;
            if (acc) $display("rand %0d: host %s %h", i, host_we ? "wr" : "rd", host_addr);
            cycle();
            disp_req = 0; fill_start = 0;
            if (acc || !host_req) begin
                host_req = ($urandom_range(0, 2) != 0);
                host_we = 1'($urandom_range(0, 1));
                host_addr = rnd_addr();
                host_wdata = DW'($urandom);
            end
        end
        host_req = 0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
